// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter for the display path.
// One shift per clock: capture on start, WIDTH shift cycles, one DONE cycle.
// Digits that fall off the top are dropped, so bcd_out is value mod 10^DIGITS,
// and overflow records that a bit ever left the top digit.

// Per-digit add-3 correction applied before each shift.
module bin_to_bcd_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  // Digits 5..9 become 8..12 so the following doubling carries into the next digit.
  assign q = (d >= 4'd5) ? (d + 4'd3) : d;
endmodule

module bin_to_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]   work_q;
  logic [BW-1:0]   work_adj;
  logic [BW-1:0]   work_nxt;
  logic            ovf_q;
  logic            ovf_nxt;
  logic [CW-1:0]   cnt_q;
  logic            last_shift;

  // All digits corrected in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin_to_bcd_digit u_dig (
      .d (work_q[4*g +: 4]),
      .q (work_adj[4*g +: 4])
    );
  end

  // Shift the corrected work register left, pulling in the next binary MSB;
  // the bit pushed out of the top digit makes the result sticky-overflowed.
  assign work_nxt   = {work_adj[BW-2:0], shift_q[WIDTH-1]};
  assign ovf_nxt    = ovf_q | work_adj[BW-1];
  assign last_shift = (cnt_q == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, shift, and publish the result on the final shift edge
  // so bcd_out/overflow change only when entering DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q  <= '0;
      work_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_q <= binary_in;
            work_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          shift_q <= shift_q << 1;
          work_q  <= work_nxt;
          ovf_q   <= ovf_nxt;
          cnt_q   <= cnt_q + CW'(1);
          if (last_shift) begin
            bcd_out  <= work_nxt;
            overflow <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: stimulus pushes expected results into a
// scoreboard queue, an independent monitor pops on every done pulse.
module tb_bin_to_bcd_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] binary_in = '0;
  logic        busy, done, overflow;
  logic [31:0] bcd_out;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  logic prev_done  = 1'b0;

  bin_to_bcd_seq #(.WIDTH(32), .DIGITS(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .binary_in (binary_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample away from the active edge, compare each done pulse.
  always @(negedge clock) begin
    if (!reset && done) begin
      chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd_out", {32'd0, bcd_out}, {32'd0, e.bcd});
        chk("overflow", {63'd0, overflow}, {63'd0, e.ovf});
      end
      for (int i = 0; i < 8; i++)
        if (bcd_out[4*i +: 4] > 4'd9) chk("nibble_le9", {60'd0, bcd_out[4*i +: 4]}, 64'd9);
    end
    prev_done = reset ? 1'b0 : done;
  end

  // Wait for the converter to be idle (bounded), then issue one conversion and
  // check the accept-to-done latency in edges (accept edge counted as 1).
  task automatic convert(input logic [31:0] v, input logic [31:0] exp_bcd, input logic exp_ovf);
    int lat;
    int guard;
    @(negedge clock);
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", 64'd1, 64'd0);
    start     = 1'b1;
    binary_in = v;
    sb.push_back('{bcd: exp_bcd, ovf: exp_ovf});
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    start     = 1'b0;
    binary_in = $urandom;
    while (!done && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk("latency", 64'(lat), 64'd33);
  endtask

  initial begin
    int gap;
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_bcd", {32'd0, bcd_out}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);

    convert(32'd0,          32'h00000000, 1'b0);
    convert(32'd12345678,   32'h12345678, 1'b0);
    // Outputs hold while idle
    repeat (5) @(negedge clock);
    chk("hold_bcd", {32'd0, bcd_out}, {32'd0, 32'h12345678});
    chk("hold_done", {63'd0, done}, 64'd0);
    convert(32'd99999999,   32'h99999999, 1'b0);
    convert(32'd100000000,  32'h00000000, 1'b1);
    convert(32'hFFFFFFFF,   32'h94967295, 1'b1);
    convert(32'd123456789,  32'h23456789, 1'b1);
    convert(32'd100000001,  32'h00000001, 1'b1);
    convert(32'd10,         32'h00000010, 1'b0);
    convert(32'd9,          32'h00000009, 1'b0);
    convert(32'd2147483648, 32'h47483648, 1'b1);

    // Start held high: change binary_in mid-run, expect back-to-back results
    @(negedge clock);
    start     = 1'b1;
    binary_in = 32'd5;
    sb.push_back('{bcd: 32'h00000005, ovf: 1'b0});
    sb.push_back('{bcd: 32'h00000007, ovf: 1'b0});
    repeat (10) @(negedge clock);
    binary_in = 32'd7;
    gap = 0;
    while (!done && gap < 100) begin
      @(negedge clock);
      gap++;
    end
    if (gap >= 100) chk("held_first_timeout", 64'd1, 64'd0);
    gap = 0;
    repeat (2) begin
      @(posedge clock);
      gap++;
    end
    @(negedge clock);
    start = 1'b0;
    chk("held_restart_busy", {63'd0, busy}, 64'd1);
    while (!done && gap < 100) begin
      @(posedge clock);
      gap++;
      @(negedge clock);
    end
    chk("restart_gap", 64'(gap), 64'd34);

    // Reset aborts a conversion in progress
    convert(32'd42, 32'h00000042, 1'b0);
    @(negedge clock);
    start     = 1'b1;
    binary_in = 32'd99;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_bcd", {32'd0, bcd_out}, 64'd0);
    chk("abort_ovf", {63'd0, overflow}, 64'd0);
    repeat (40) @(negedge clock);
    convert(32'd7, 32'h00000007, 1'b0);

    repeat (3) @(negedge clock);
    chk("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
